// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests and
// buffers responses in a one-entry skid so decode back-pressure never loses an instruction.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_jmp_flag,
    input  logic [31:0] br_target,
    input  logic        exception_flag,
    input  logic [31:0] mtvec,
    input  logic        mret_flag_in,
    input  logic [31:0] mepc,
    input  logic        exception_stalled,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [63:0] if_id_bus_out,
    output logic [5:0]  exception_code_fd,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state, state_next;
    logic [31:0] fetch_pc, req_addr, redirect_pc;
    logic        discard, exc_pend;
    logic        out_v, skid_v;
    logic [63:0] out_bus, skid_bus, resp_bus;
    logic [5:0]  out_code;
    logic        redirect, flush, resp_in, accept, drain, out_free;
    logic        skid_v_next, issue_ok, new_req, exc_load;

    always_comb begin
        redirect = exception_flag | mret_flag_in | br_jmp_flag;
        if (exception_flag)
            redirect_pc = mtvec;
        else if (mret_flag_in)
            redirect_pc = mepc;
        else
            redirect_pc = br_target;
    end

    assign flush       = redirect | exception_stalled;
    assign resp_in     = (state == S_WAIT) && inst_rvalid;
    assign accept      = resp_in && !discard && !flush;
    assign resp_bus    = {inst_rdata, req_addr};
    assign drain       = out_v && ds_allowin;
    assign out_free    = !out_v || drain;
    assign skid_v_next = out_free ? (skid_v && accept) : (skid_v || accept);
    assign exc_load    = out_free && !skid_v && !accept && exc_pend;

    // A new request may only go out if its response is guaranteed a free slot.
    assign issue_ok  = rst_n && !flush && (fetch_pc[1:0] == 2'b00) && !skid_v_next;
    assign new_req   = issue_ok && ((state == S_IDLE) || resp_in);
    assign inst_req  = (state == S_REQ) || new_req;
    assign inst_addr = (state == S_REQ) ? req_addr : fetch_pc;

    assign fs_to_ds_valid    = out_v;
    assign if_id_bus_out     = out_bus;
    assign exception_code_fd = out_code;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (new_req) state_next = inst_gnt ? S_WAIT : S_REQ;
            S_REQ:   if (inst_gnt) state_next = S_WAIT;
            S_WAIT:  if (inst_rvalid) state_next = new_req ? (inst_gnt ? S_WAIT : S_REQ) : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A stall that kills a live response rewinds the PC so that instruction is refetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
            exc_pend <= 1'b0;
        end else begin
            state <= state_next;
            if (new_req)
                req_addr <= fetch_pc;
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (exception_stalled && (state == S_WAIT) && !discard)
                fetch_pc <= req_addr;
            else if (inst_req && inst_gnt && !exception_stalled && !((state == S_REQ) && discard))
                fetch_pc <= fetch_pc + 32'd4;
            if (flush && ((state == S_REQ) || ((state == S_WAIT) && !inst_rvalid)))
                discard <= 1'b1;
            else if (resp_in)
                discard <= 1'b0;
            if (redirect)
                exc_pend <= (redirect_pc[1:0] != 2'b00);
            else if (!exception_stalled && exc_load)
                exc_pend <= 1'b0;
        end
    end

    // Output register refills from the skid first, then a fresh response, then a fetch fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v    <= 1'b0;
            out_bus  <= 64'd0;
            out_code <= 6'd0;
            skid_v   <= 1'b0;
            skid_bus <= 64'd0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_free) begin
            if (skid_v) begin
                out_v    <= 1'b1;
                out_bus  <= skid_bus;
                out_code <= 6'd0;
                skid_v   <= accept;
                if (accept)
                    skid_bus <= resp_bus;
            end else if (accept) begin
                out_v    <= 1'b1;
                out_bus  <= resp_bus;
                out_code <= 6'd0;
            end else if (exc_load) begin
                out_v    <= 1'b1;
                out_bus  <= {NOP_INST, fetch_pc};
                out_code <= 6'b100000;
            end else begin
                out_v <= 1'b0;
            end
        end else if (accept) begin
            skid_v   <= 1'b1;
            skid_bus <= resp_bus;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a tiny imem responder (data = ~addr) and hand-computed expectations.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        br_jmp_flag;
    logic [31:0] br_target;
    logic        exception_flag;
    logic [31:0] mtvec;
    logic        mret_flag_in;
    logic [31:0] mepc;
    logic        exception_stalled;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [63:0] if_id_bus_out;
    logic [5:0]  exception_code_fd;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    int          checks = 0;
    int          errors = 0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_pend_addr = 32'd0;
    logic        mem_hold = 1'b0;
    logic        req_seen;
    logic [31:0] addr_seen;

    if_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .br_jmp_flag       (br_jmp_flag),
        .br_target         (br_target),
        .exception_flag    (exception_flag),
        .mtvec             (mtvec),
        .mret_flag_in      (mret_flag_in),
        .mepc              (mepc),
        .exception_stalled (exception_stalled),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .if_id_bus_out     (if_id_bus_out),
        .exception_code_fd (exception_code_fd),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_gnt          (inst_gnt),
        .inst_rvalid       (inst_rvalid),
        .inst_rdata        (inst_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkEntry(input string tag, input logic valid, input logic [63:0] bus, input logic [5:0] code);
        checkOutput({tag, "_valid"}, {63'd0, fs_to_ds_valid}, {63'd0, valid});
        if (valid) begin
            checkOutput({tag, "_bus"}, if_id_bus_out, bus);
            checkOutput({tag, "_code"}, {58'd0, exception_code_fd}, {58'd0, code});
        end
    endtask

    task automatic checkReq(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, "_req"}, {63'd0, req_seen}, {63'd0, req});
        if (req)
            checkOutput({tag, "_addr"}, {32'd0, addr_seen}, {32'd0, addr});
    endtask

    // One clock of the imem responder: respond to last grant, grant any request, then clock.
    task automatic applyStimulus();
        inst_rvalid = mem_pend && !mem_hold;
        inst_rdata  = inst_rvalid ? ~mem_pend_addr : 32'd0;
        #1;
        inst_gnt = inst_req;
        #1;
        req_seen  = inst_req;
        addr_seen = inst_addr;
        @(posedge clk);
        if (inst_rvalid)
            mem_pend = 1'b0;
        if (req_seen && inst_gnt) begin
            mem_pend      = 1'b1;
            mem_pend_addr = addr_seen;
        end
        @(negedge clk);
        inst_gnt    = 1'b0;
        inst_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        br_jmp_flag = 1'b0;
        br_target = 32'd0;
        exception_flag = 1'b0;
        mtvec = 32'd0;
        mret_flag_in = 1'b0;
        mepc = 32'd0;
        exception_stalled = 1'b0;
        ds_allowin = 1'b1;
        inst_gnt = 1'b0;
        inst_rvalid = 1'b0;
        inst_rdata = 32'd0;

        applyStimulus();
        applyStimulus();
        checkReq("rst_req", 1'b0, 32'd0);
        checkOutput("rst_addr", {32'd0, inst_addr}, {32'd0, 32'h8000_0000});
        checkEntry("rst_out", 1'b0, 64'd0, 6'd0);
        checkOutput("rst_bus", if_id_bus_out, 64'd0);
        checkOutput("rst_code", {58'd0, exception_code_fd}, 64'd0);

        rst_n = 1'b1;
        applyStimulus();
        checkReq("c0", 1'b1, 32'h8000_0000);
        checkEntry("c0", 1'b0, 64'd0, 6'd0);
        applyStimulus();
        checkReq("c1", 1'b1, 32'h8000_0004);
        checkEntry("c1", 1'b1, 64'h7FFF_FFFF_8000_0000, 6'd0);
        applyStimulus();
        checkReq("c2", 1'b1, 32'h8000_0008);
        checkEntry("c2", 1'b1, 64'h7FFF_FFFB_8000_0004, 6'd0);
        applyStimulus();
        checkReq("c3", 1'b1, 32'h8000_000C);
        checkEntry("c3", 1'b1, 64'h7FFF_FFF7_8000_0008, 6'd0);

        $display("[TB] decode back-pressure for 4 cycles");
        ds_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkReq("bp_req", 1'b0, 32'd0);
            checkEntry("bp_hold", 1'b1, 64'h7FFF_FFF7_8000_0008, 6'd0);
        end
        ds_allowin = 1'b1;
        applyStimulus();
        checkReq("bp_rel", 1'b1, 32'h8000_0010);
        checkEntry("bp_skid", 1'b1, 64'h7FFF_FFF3_8000_000C, 6'd0);
        applyStimulus();
        checkReq("bp_next", 1'b1, 32'h8000_0014);
        checkEntry("bp_next", 1'b1, 64'h7FFF_FFEF_8000_0010, 6'd0);

        $display("[TB] branch while waiting for a response");
        mem_hold = 1'b1;
        br_jmp_flag = 1'b1;
        br_target = 32'h8000_0100;
        applyStimulus();
        checkReq("br_cyc", 1'b0, 32'd0);
        checkEntry("br_flush", 1'b0, 64'd0, 6'd0);
        br_jmp_flag = 1'b0;
        mem_hold = 1'b0;
        applyStimulus();
        checkReq("br_new", 1'b1, 32'h8000_0100);
        checkEntry("br_drop", 1'b0, 64'd0, 6'd0);
        applyStimulus();
        checkEntry("br_tgt", 1'b1, 64'h7FFF_FEFF_8000_0100, 6'd0);

        $display("[TB] trap and branch together");
        exception_flag = 1'b1;
        mtvec = 32'h8000_0040;
        br_jmp_flag = 1'b1;
        br_target = 32'h8000_0200;
        applyStimulus();
        checkReq("trap_cyc", 1'b0, 32'd0);
        checkEntry("trap_drop", 1'b0, 64'd0, 6'd0);
        exception_flag = 1'b0;
        br_jmp_flag = 1'b0;
        applyStimulus();
        checkReq("trap_new", 1'b1, 32'h8000_0040);
        applyStimulus();
        checkEntry("trap_tgt", 1'b1, 64'h7FFF_FFBF_8000_0040, 6'd0);

        $display("[TB] misaligned branch target");
        br_jmp_flag = 1'b1;
        br_target = 32'h8000_0102;
        applyStimulus();
        checkReq("mis_cyc", 1'b0, 32'd0);
        checkEntry("mis_flush", 1'b0, 64'd0, 6'd0);
        br_jmp_flag = 1'b0;
        applyStimulus();
        checkReq("mis_noreq", 1'b0, 32'd0);
        checkEntry("mis_entry", 1'b1, 64'h0000_0033_8000_0102, 6'b100000);
        applyStimulus();
        checkReq("mis_idle1", 1'b0, 32'd0);
        checkEntry("mis_drain", 1'b0, 64'd0, 6'd0);
        applyStimulus();
        checkReq("mis_idle2", 1'b0, 32'd0);

        $display("[TB] reset while waiting");
        br_jmp_flag = 1'b1;
        br_target = 32'h8000_0300;
        applyStimulus();
        br_jmp_flag = 1'b0;
        mem_hold = 1'b1;
        applyStimulus();
        checkReq("rw_req", 1'b1, 32'h8000_0300);
        rst_n = 1'b0;
        #1;
        checkOutput("rw_inst_req", {63'd0, inst_req}, 64'd0);
        checkOutput("rw_inst_addr", {32'd0, inst_addr}, {32'd0, 32'h8000_0000});
        checkOutput("rw_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        checkOutput("rw_bus", if_id_bus_out, 64'd0);
        checkOutput("rw_code", {58'd0, exception_code_fd}, 64'd0);
        mem_hold = 1'b0;
        applyStimulus();
        checkEntry("rw_late", 1'b0, 64'd0, 6'd0);
        mem_pend = 1'b0;
        rst_n = 1'b1;
        applyStimulus();
        checkReq("rw_restart", 1'b1, 32'h8000_0000);
        checkEntry("rw_restart", 1'b0, 64'd0, 6'd0);
        applyStimulus();
        checkEntry("rw_first", 1'b1, 64'h7FFF_FFFF_8000_0000, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV32 pipeline; sits directly upstream of the decode stage and produces its 64-bit `{inst, pc}` bus, `fs_to_ds_valid` and the 6-bit fetch exception code. It owns the PC, issues single-outstanding requests to the instruction memory over a req/gnt/rvalid handshake, and buffers responses in a 1-entry skid buffer so decode back-pressure never loses an instruction. It redirects on trap entry, mret and branch/jump, discarding any in-flight response that belongs to the old path.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0033, instruction emitted with a fetch exception (ADD x0,x0,x0).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- br_jmp_flag  in  1  branch/jump taken, from execute.
- br_target  in  32  branch/jump target.
- exception_flag  in  1  trap entry.
- mtvec  in  32  trap vector.
- mret_flag_in  in  1  mret retire.
- mepc  in  32  mret return address.
- exception_stalled  in  1  pipeline held for trap handling.
- ds_allowin  in  1  decode can accept this cycle.
- fs_to_ds_valid  out  1  output entry valid.
- if_id_bus_out  out  64  {inst[63:32], pc[31:0]}.
- exception_code_fd  out  6  bit 5 = exception; 6'b100000 = fetch address misaligned.
- inst_req  out  1  imem request.
- inst_addr  out  32  imem word address (byte address, [1:0]=0 when req).
- inst_gnt  in  1  request accepted this cycle.
- inst_rvalid  in  1  response valid (≥1 cycle after gnt).
- inst_rdata  in  32  response instruction.

## Operation
- Request FSM: IDLE (none outstanding), REQ (inst_req high, awaiting gnt), WAIT (granted, awaiting rvalid).
- IDLE→REQ when skid empty, not exception_stalled, and fetch_pc[1:0]==0; REQ→WAIT on gnt; WAIT→IDLE on rvalid, or WAIT→REQ in the same cycle if the issue conditions hold with the skid free after this cycle.
- inst_addr = fetch_pc, stable while REQ; fetch_pc += 4 on gnt, wrapping 32'hFFFF_FFFC→0.
- Response goes to output register if empty or draining (fs_to_ds_valid && ds_allowin), else to skid. Output refills from skid first on drain.
- Redirect priority: exception_flag (mtvec) > mret_flag_in (mepc) > br_jmp_flag (br_target). On redirect: fetch_pc←target, output and skid cleared, discard flag set if state is REQ or WAIT; the next rvalid is dropped and clears the flag.
- Redirect while in REQ: inst_req/inst_addr held until gnt (no request withdrawal); that response is discarded.
- Misaligned target ([1:0]≠0): no imem request; one entry {NOP_INST, target} with exception_code_fd=6'b100000 is loaded when the output frees, then fetch idles until the next redirect.
- exception_stalled: no new requests; output and skid flushed; fs_to_ds_valid=0; outstanding response discarded.

## Timing
- Reset: fetch_pc=RESET_PC, state IDLE, inst_req=0, inst_addr=RESET_PC, fs_to_ds_valid=0, if_id_bus_out=0, exception_code_fd=0, discard=0.
- First inst_req in the first cycle after rst_n deasserts.
- Registered outputs: rvalid in cycle N → fs_to_ds_valid in N+1.
- With gnt same cycle and rvalid next cycle, sustained throughput is 1 instr/cycle with no stalls.
- Redirect in cycle N: fs_to_ds_valid=0 in N+1; new-path request no earlier than N+1.
- Redirect and rvalid in the same cycle: response dropped.
- Skid and output both full: no request issued; nothing is ever dropped except by redirect/flush.

## Test plan
- Reset, gnt=1 always, rvalid 1 cycle later: addresses 8000_0000, _0004, _0008 back-to-back; fs_to_ds_valid from cycle 2; bus = {rdata, pc}.
- ds_allowin=0 for 4 cycles mid-stream: output holds, skid fills, inst_req stops; on release, entries emerge in order, no loss or duplication.
- br_jmp_flag with target 8000_0100 while WAIT: old rvalid dropped; next fs_to_ds_valid carries pc=8000_0100.
- exception_flag and br_jmp_flag in the same cycle, mtvec=8000_0040: fetch resumes at 8000_0040.
- br_target=8000_0102: no inst_req; one entry {0000_0033, 8000_0102}, code 6'b100000; fetch idles.
- rst_n asserted while in WAIT: all outputs return to reset values immediately; late rvalid ignored.
